// File: rtl/seq_alarm_ctrl.sv
// Alarm controller: stores an alarm time, detects the clock reaching it and runs a
// ring / snooze / dismiss FSM. Optional hourly chime is enabled by ALARM_HOURLY_CHIME_EN.
module seq_alarm_ctrl #(
  parameter int RING_MINS   = 10,
  parameter int SNOOZE_MINS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] hours,
  input  logic [5:0] mins,
  input  logic       pm,
  input  logic       alarm_on,
  input  logic       alarm_set_en,
  input  logic [3:0] alarm_set_hours,
  input  logic [5:0] alarm_set_mins,
  input  logic       alarm_set_pm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [3:0] alarm_hours,
  output logic [5:0] alarm_mins,
  output logic       alarm_pm,
  output logic       ringing,
  output logic       snoozing,
  output logic       chime
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [5:0] RING_LAST    = 6'(RING_MINS - 1);
  localparam logic [5:0] SNOOZE_LAST  = 6'(SNOOZE_MINS - 1);
  localparam logic [2:0] SNOOZE_LIMIT = 3'(MAX_SNOOZE);

  state_t     state;
  logic [5:0] ring_cnt;
  logic [5:0] snooze_cnt;
  logic [2:0] snoozes_used;
  logic       match;
  logic       match_prev;
  logic       trigger;
  logic       set_valid;

  assign set_valid = (alarm_set_hours != 4'd0) && (alarm_set_hours <= 4'd12) &&
                     (alarm_set_mins <= 6'd59);
  assign match     = (hours == alarm_hours) && (mins == alarm_mins) && (pm == alarm_pm);
  // Edge-detect so a clock that sits on the alarm time fires only once.
  assign trigger   = match && !match_prev;

  // NOTE: sequential state is always assigned with <=, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hours <= 4'd12;
      alarm_mins  <= 6'd0;
      alarm_pm    <= 1'b0;
    end else if (alarm_set_en && set_valid) begin
      alarm_hours <= alarm_set_hours;
      alarm_mins  <= alarm_set_mins;
      alarm_pm    <= alarm_set_pm;
    end
  end

  // Reset value of 1 keeps a clock that powers up on 12:00 AM from ringing.
  always_ff @(posedge clk) begin
    if (reset) match_prev <= 1'b1;
    else       match_prev <= match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      ring_cnt     <= 6'd0;
      snooze_cnt   <= 6'd0;
      snoozes_used <= 3'd0;
    end else if (!alarm_on || (dismiss && state != IDLE)) begin
      state        <= IDLE;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      snoozes_used <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= RING;
            ringing  <= 1'b1;
            ring_cnt <= 6'd0;
          end
        end
        RING: begin
          if (snooze && snoozes_used < SNOOZE_LIMIT) begin
            state        <= SNOOZE;
            ringing      <= 1'b0;
            snoozing     <= 1'b1;
            snooze_cnt   <= 6'd0;
            snoozes_used <= snoozes_used + 3'd1;
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              state        <= IDLE;
              ringing      <= 1'b0;
              snoozes_used <= 3'd0;
            end else begin
              ring_cnt <= ring_cnt + 6'd1;
            end
          end
        end
        SNOOZE: begin
          if (tick) begin
            if (snooze_cnt == SNOOZE_LAST) begin
              state    <= RING;
              ringing  <= 1'b1;
              snoozing <= 1'b0;
              ring_cnt <= 6'd0;
            end else begin
              snooze_cnt <= snooze_cnt + 6'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALARM_HOURLY_CHIME_EN
  logic [5:0] mins_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      mins_prev <= 6'd0;
      chime     <= 1'b0;
    end else begin
      mins_prev <= mins;
      chime     <= (mins == 6'd0) && (mins_prev == 6'd59) && alarm_on;
    end
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alarm_ctrl.sv
// Directed bench for seq_alarm_ctrl: table of alarm-load vectors plus hand-written
// sequences for ring timeout, snooze limit, dismiss, enable drop, reset and chime.
module tb_seq_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] hours;
  logic [5:0] mins;
  logic       pm;
  logic       alarm_on;
  logic       alarm_set_en;
  logic [3:0] alarm_set_hours;
  logic [5:0] alarm_set_mins;
  logic       alarm_set_pm;
  logic       snooze;
  logic       dismiss;
  logic [3:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic       alarm_pm;
  logic       ringing;
  logic       snoozing;
  logic       chime;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alarm_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .hours(hours), .mins(mins), .pm(pm),
    .alarm_on(alarm_on), .alarm_set_en(alarm_set_en), .alarm_set_hours(alarm_set_hours),
    .alarm_set_mins(alarm_set_mins), .alarm_set_pm(alarm_set_pm), .snooze(snooze),
    .dismiss(dismiss), .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
    .alarm_pm(alarm_pm), .ringing(ringing), .snoozing(snoozing), .chime(chime)
  );

  typedef struct {
    string      name;
    logic       set_en;
    logic [3:0] sh;
    logic [5:0] sm;
    logic       sp;
    logic [3:0] eh;
    logic [5:0] em;
    logic       ep;
  } load_vec_t;

  load_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model of the upstream 12-hour counter: minutes advance on the edge that sees tick.
  task automatic tick_min();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    if (mins == 6'd59) begin
      mins = 6'd0;
      if (hours == 4'd11) begin
        hours = 4'd12;
        pm    = ~pm;
      end else if (hours == 4'd12) begin
        hours = 4'd1;
      end else begin
        hours = hours + 4'd1;
      end
    end else begin
      mins = mins + 6'd1;
    end
  endtask

  task automatic load_alarm(input logic [3:0] h, input logic [5:0] m, input logic p);
    alarm_set_en    = 1'b1;
    alarm_set_hours = h;
    alarm_set_mins  = m;
    alarm_set_pm    = p;
    cyc();
    alarm_set_en    = 1'b0;
  endtask

  task automatic set_clock(input logic [3:0] h, input logic [5:0] m, input logic p);
    hours = h;
    mins  = m;
    pm    = p;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_chime;
`ifdef ALARM_HOURLY_CHIME_EN
    exp_chime = 1'b1;
`else
    exp_chime = 1'b0;
`endif
    vecs[0] = '{"load_13_00",      1'b1, 4'd13, 6'd0,  1'b0, 4'd12, 6'd0,  1'b0};
    vecs[1] = '{"load_0_30",       1'b1, 4'd0,  6'd30, 1'b0, 4'd12, 6'd0,  1'b0};
    vecs[2] = '{"load_12_60",      1'b1, 4'd12, 6'd60, 1'b0, 4'd12, 6'd0,  1'b0};
    vecs[3] = '{"load_12_59_pm",   1'b1, 4'd12, 6'd59, 1'b1, 4'd12, 6'd59, 1'b1};
    vecs[4] = '{"load_15_10",      1'b1, 4'd15, 6'd10, 1'b0, 4'd12, 6'd59, 1'b1};
    vecs[5] = '{"no_set_en",       1'b0, 4'd3,  6'd15, 1'b0, 4'd12, 6'd59, 1'b1};
    vecs[6] = '{"load_1_00_am",    1'b1, 4'd1,  6'd0,  1'b0, 4'd1,  6'd0,  1'b0};
    vecs[7] = '{"load_1_02_am",    1'b1, 4'd1,  6'd2,  1'b0, 4'd1,  6'd2,  1'b0};

    reset = 1'b1; tick = 1'b0; alarm_on = 1'b0; alarm_set_en = 1'b0;
    alarm_set_hours = 4'd0; alarm_set_mins = 6'd0; alarm_set_pm = 1'b0;
    snooze = 1'b0; dismiss = 1'b0;
    set_clock(4'd5, 6'd30, 1'b0);
    cyc();
    cyc();
    check("rst_alarm_hours", 32'(alarm_hours), 32'd12);
    check("rst_alarm_mins",  32'(alarm_mins),  32'd0);
    check("rst_alarm_pm",    32'(alarm_pm),    32'd0);
    check("rst_ringing",     32'(ringing),     32'd0);
    check("rst_snoozing",    32'(snoozing),    32'd0);
    check("rst_chime",       32'(chime),       32'd0);
    reset = 1'b0;

    // Alarm load validation, clock parked away from every loaded value
    for (int i = 0; i < 8; i++) begin
      alarm_set_en    = vecs[i].set_en;
      alarm_set_hours = vecs[i].sh;
      alarm_set_mins  = vecs[i].sm;
      alarm_set_pm    = vecs[i].sp;
      cyc();
      alarm_set_en = 1'b0;
      check({vecs[i].name, "_h"}, 32'(alarm_hours), 32'(vecs[i].eh));
      check({vecs[i].name, "_m"}, 32'(alarm_mins),  32'(vecs[i].em));
      check({vecs[i].name, "_p"}, 32'(alarm_pm),    32'(vecs[i].ep));
      check({vecs[i].name, "_ring"}, 32'(ringing), 32'd0);
    end

    // Ring at 1:02 AM, automatic timeout after RING_MINS ticks
    alarm_on = 1'b1;
    set_clock(4'd1, 6'd0, 1'b0);
    cyc();
    check("t1_idle", 32'(ringing), 32'd0);
    tick_min();
    check("t1_at_0101", 32'(ringing), 32'd0);
    tick_min();
    check("t1_edge_sees_0101", 32'(ringing), 32'd0);
    cyc();
    check("t1_ring_rise", 32'(ringing), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      tick_min();
      check("t1_ring_hold", 32'(ringing), 32'd1);
    end
    tick_min();
    check("t1_ring_timeout", 32'(ringing), 32'd0);

    // Load alarm equal to current time 7:45 PM: rings two edges after set_en
    set_clock(4'd7, 6'd45, 1'b1);
    cyc();
    load_alarm(4'd7, 6'd45, 1'b1);
    check("t2_load_edge", 32'(ringing), 32'd0);
    cyc();
    check("t2_ring", 32'(ringing), 32'd1);
    for (int s = 0; s < 3; s++) begin
      snooze = 1'b1;
      cyc();
      snooze = 1'b0;
      check("t2_snoozing", 32'(snoozing), 32'd1);
      check("t2_snooze_quiet", 32'(ringing), 32'd0);
      for (int i = 0; i < 4; i++) tick_min();
      check("t2_snooze_hold", 32'(snoozing), 32'd1);
      tick_min();
      check("t2_rering", 32'(ringing), 32'd1);
      check("t2_rering_nosnz", 32'(snoozing), 32'd0);
    end
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    check("t2_snooze_limit_ring", 32'(ringing), 32'd1);
    check("t2_snooze_limit_snz", 32'(snoozing), 32'd0);
    dismiss = 1'b1;
    cyc();
    dismiss = 1'b0;
    check("t2_dismiss", 32'(ringing), 32'd0);

    // Dismiss while the clock keeps matching: no re-trigger (clock now 8:00 PM)
    load_alarm(4'd8, 6'd0, 1'b1);
    cyc();
    check("t3_ring", 32'(ringing), 32'd1);
    dismiss = 1'b1;
    cyc();
    dismiss = 1'b0;
    check("t3_dismiss", 32'(ringing), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("t3_no_retrigger", 32'(ringing), 32'd0);
    end

    // Snooze count was cleared by dismiss; drop alarm_on in SNOOZE
    load_alarm(4'd8, 6'd1, 1'b1);
    tick_min();
    check("t5_edge_sees_0800", 32'(ringing), 32'd0);
    cyc();
    check("t5_ring", 32'(ringing), 32'd1);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    check("t5_snooze_after_clear", 32'(snoozing), 32'd1);
    alarm_on = 1'b0;
    cyc();
    check("t5_off_snoozing", 32'(snoozing), 32'd0);
    check("t5_off_ringing", 32'(ringing), 32'd0);
    alarm_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t5_on_no_ring", 32'(ringing), 32'd0);
    end

    // Reset mid-ring
    load_alarm(4'd8, 6'd2, 1'b1);
    tick_min();
    cyc();
    check("t5_ring2", 32'(ringing), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t5_rst_ringing", 32'(ringing), 32'd0);
    check("t5_rst_snoozing", 32'(snoozing), 32'd0);
    check("t5_rst_alarm_h", 32'(alarm_hours), 32'd12);
    check("t5_rst_alarm_m", 32'(alarm_mins), 32'd0);
    check("t5_rst_alarm_p", 32'(alarm_pm), 32'd0);
    check("t5_rst_chime", 32'(chime), 32'd0);

    // Wrap 11:59 PM -> 12:00 AM: hourly chime and match on the reset alarm time
    set_clock(4'd11, 6'd59, 1'b1);
    cyc();
    cyc();
    check("t6_pre_chime", 32'(chime), 32'd0);
    tick_min();
    check("t6_wrap_chime", 32'(chime), 32'd0);
    check("t6_wrap_ring", 32'(ringing), 32'd0);
    cyc();
    check("t6_chime_pulse", 32'(chime), 32'(exp_chime));
    check("t6_midnight_ring", 32'(ringing), 32'd1);
    cyc();
    check("t6_chime_end", 32'(chime), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
